// File: rtl/if_pc_ctrl_pkg.sv
// Shared core defines: RV32 opcode/func3 constants plus the fetch-controller
// state encoding and the NOP word loaded into IF/ID at reset.
package if_pc_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_pc_ctrl_if.sv
// Instruction-memory request/response channel between the fetch controller
// (master) and the instruction memory (slave).
interface if_pc_ctrl_if;
    import if_pc_ctrl_pkg::*;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_pc_ctrl.sv
// Fetch-stage PC controller: single-outstanding imem requests, IF/ID register,
// stall hold buffer and execute-stage redirect with stale-response discard.
module if_pc_ctrl
    import if_pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              modify_pc,
    input  logic [XLEN-1:0]   update_pc,
    if_pc_ctrl_if.master      imem,
    output logic              if_valid,
    output logic [XLEN-1:0]   if_pc,
    output logic [XLEN-1:0]   if_instr,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              misaligned
);

    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    fetch_state_e    state_p0, state_n;
    logic [XLEN-1:0] pc_p0;
    logic [XLEN-1:0] hold_buf_p0;
    logic            discard_p0, discard_n;
    logic            load_rsp, load_buf, capture, advance;
    logic            req_fire;

    assign imem.imem_req_valid = (state_p0 == ST_REQ) && !stall && !modify_pc && !rst;
    assign imem.imem_req_addr  = pc_p0;
    assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    assign flush_ifid          = modify_pc;
    assign flush_idex          = modify_pc;

    always_comb begin
        state_n   = state_p0;
        discard_n = discard_p0;
        load_rsp  = 1'b0;
        load_buf  = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        unique case (state_p0)
            ST_REQ: begin
                if (req_fire) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    // Any response paired with a redirect or a pending discard is stale.
                    if (modify_pc || discard_p0) begin
                        discard_n = 1'b0;
                        state_n   = ST_REQ;
                    end else if (stall) begin
                        capture = 1'b1;
                        state_n = ST_HOLD;
                    end else begin
                        load_rsp = 1'b1;
                        advance  = 1'b1;
                        state_n  = ST_REQ;
                    end
                end else if (modify_pc) begin
                    discard_n = 1'b1;
                end
            end
            ST_HOLD: begin
                if (modify_pc) begin
                    state_n = ST_REQ;
                end else if (!stall) begin
                    load_buf = 1'b1;
                    advance  = 1'b1;
                    state_n  = ST_REQ;
                end
            end
            default: state_n = ST_REQ;
        endcase
    end

    // ---- p0: fetch control state, PC and hold buffer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0    <= ST_REQ;
            // A request abandoned by reset may still answer; drop that reply.
            discard_p0  <= (state_p0 == ST_WAIT);
            pc_p0       <= RESET_PC;
            hold_buf_p0 <= '0;
            misaligned  <= 1'b0;
        end else begin
            state_p0   <= state_n;
            discard_p0 <= discard_n;
            misaligned <= modify_pc && (update_pc[1:0] != 2'b00);
            if (modify_pc)    pc_p0 <= {update_pc[31:2], 2'b00};
            else if (advance) pc_p0 <= pc_plus4(pc_p0);
            if (capture)      hold_buf_p0 <= imem.imem_rsp_data;
        end
    end

    // ---- IF/ID output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= NOP_INSTR;
        end else if (modify_pc) begin
            if_valid <= 1'b0;
        end else if (!stall) begin
            if_valid <= load_rsp || load_buf;
            if (load_rsp) begin
                if_pc    <= pc_p0;
                if_instr <= imem.imem_rsp_data;
            end else if (load_buf) begin
                if_pc    <= pc_p0;
                if_instr <= hold_buf_p0;
            end
        end
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Directed bench for if_pc_ctrl: sequential fetch, stall hold, redirects,
// misaligned target, PC wrap and reset while a request is outstanding.
module tb_if_pc_ctrl;
    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        modify_pc = 1'b0;
    logic [31:0] update_pc = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_ifid;
    logic        flush_idex;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    if_pc_ctrl_if bus ();

    if_pc_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .modify_pc  (modify_pc),
        .update_pc  (update_pc),
        .imem       (bus.master),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;

        // Reset
        tick();
        tick();
        chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_addr", bus.imem_req_addr, RST_PC);

        // Sequential fetch, one instruction per two cycles
        bus.imem_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("seq_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("seq_addr", bus.imem_req_addr, RST_PC + 32'(4 * k));
            tick();
            chk("seq_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
            chk("seq_bubble", {31'd0, if_valid}, 32'd0);
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'h0000_1000 + 32'(k);
            tick();
            bus.imem_rsp_valid = 1'b0;
            chk("seq_if_valid", {31'd0, if_valid}, 32'd1);
            chk("seq_if_pc", if_pc, RST_PC + 32'(4 * k));
            chk("seq_if_instr", if_instr, 32'h0000_1000 + 32'(k));
        end

        // Stall as the response arrives (request to 0x90)
        tick();
        chk("stall_bubble", {31'd0, if_valid}, 32'd0);
        stall = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00A0_0093;
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'hFFFF_FFFF;
        chk("stall_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        tick();
        chk("stall_hold_valid", {31'd0, if_valid}, 32'd0);
        chk("stall_hold_pc", if_pc, 32'h0000_008C);
        chk("stall_hold_instr", if_instr, 32'h0000_1003);
        stall = 1'b0;
        tick();
        chk("stall_rel_valid", {31'd0, if_valid}, 32'd1);
        chk("stall_rel_pc", if_pc, 32'h0000_0090);
        chk("stall_rel_instr", if_instr, 32'h00A0_0093);
        chk("stall_rel_addr", bus.imem_req_addr, 32'h0000_0094);

        // Redirect while waiting, before the response
        tick();
        modify_pc = 1'b1;
        update_pc = 32'h0000_0100;
        #1;
        chk("redir_flush_ifid", {31'd0, flush_ifid}, 32'd1);
        chk("redir_flush_idex", {31'd0, flush_idex}, 32'd1);
        tick();
        modify_pc = 1'b0;
        #1;
        chk("redir_flush_clr", {31'd0, flush_ifid}, 32'd0);
        chk("redir_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_wait_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("redir_stale_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_stale_instr", if_instr, 32'h00A0_0093);
        chk("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("redir_addr", bus.imem_req_addr, 32'h0000_0100);

        // Redirect with stall and a same-cycle response
        tick();
        modify_pc = 1'b1;
        update_pc = 32'h0000_0200;
        stall = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0BAD_F00D;
        tick();
        modify_pc = 1'b0;
        stall = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("rs_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rs_if_instr", if_instr, 32'h00A0_0093);
        chk("rs_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("rs_addr", bus.imem_req_addr, 32'h0000_0200);

        // Misaligned redirect target
        modify_pc = 1'b1;
        update_pc = 32'h0000_0206;
        #1;
        chk("mis_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        modify_pc = 1'b0;
        #1;
        chk("mis_pulse", {31'd0, misaligned}, 32'd1);
        chk("mis_addr", bus.imem_req_addr, 32'h0000_0204);
        tick();
        chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0055;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("mis_if_pc", if_pc, 32'h0000_0204);

        // PC wrap
        modify_pc = 1'b1;
        update_pc = 32'hFFFF_FFFC;
        tick();
        modify_pc = 1'b0;
        #1;
        chk("wrap_addr_pre", bus.imem_req_addr, 32'hFFFF_FFFC);
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0077;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_instr", if_instr, 32'h0000_0077);
        chk("wrap_addr", bus.imem_req_addr, 32'h0000_0000);

        // Reset while a request is outstanding
        tick();
        rst = 1'b1;
        #1;
        chk("rstw_no_req", {31'd0, bus.imem_req_valid}, 32'd0);
        tick();
        rst = 1'b0;
        bus.imem_req_ready = 1'b0;
        #1;
        chk("rstw_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rstw_if_instr", if_instr, 32'h0000_0013);
        chk("rstw_addr", bus.imem_req_addr, RST_PC);
        tick();
        chk("rstw_not_ready_hold", {31'd0, bus.imem_req_valid}, 32'd1);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0BAD;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("rstw_late_valid", {31'd0, if_valid}, 32'd0);
        chk("rstw_late_instr", if_instr, 32'h0000_0013);
        chk("rstw_reissue", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("rstw_reissue_addr", bus.imem_req_addr, RST_PC);
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0099;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("rstw_fetch_pc", if_pc, RST_PC);
        chk("rstw_fetch_instr", if_instr, 32'h0000_0099);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
